// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl
// ATM session sequencer. It handles card insertion, language selection,
// strobed PIN entry with a bounded retry count and lockout, and a transaction
// menu: show balance, withdraw, deposit and change PIN. A session that sees
// no strobe for TIMEOUT_CYCLES cycles is ejected. Every output is registered.
//
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   card_in        card present (level), sampled in IDLE only
//   lang_sel       language chosen (strobe)
//   pin_in         keypad PIN, qualified by pin_valid (one attempt per cycle)
//   op, op_valid   menu choice: 00 balance, 01 withdraw, 10 deposit, 11 new PIN
//   amount         transaction amount; its low PIN_W bits are the new PIN
//   amount_valid   amount strobe
//   exit           abort the session (eject card)
//   home           leave a transaction screen and return to MENU
//   balance_out    current balance
//   state_out      state code (see state_t)
//   txn_ok/txn_err one-cycle transaction result pulses
//   card_eject     one-cycle pulse while in EJECT
//   card_locked    high while LOCKED
//   tries_left     remaining PIN attempts
module atm_session_ctrl #(
    parameter int                PIN_W          = 4,
    parameter int                BAL_W          = 8,
    parameter int                AMT_W          = 6,
    parameter int                MAX_TRIES      = 3,
    parameter int                INIT_BALANCE   = 30,
    parameter logic [PIN_W-1:0]  DEFAULT_PIN    = '1,
    parameter int                TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             card_in,
    input  logic             lang_sel,
    input  logic [PIN_W-1:0] pin_in,
    input  logic             pin_valid,
    input  logic [1:0]       op,
    input  logic             op_valid,
    input  logic [AMT_W-1:0] amount,
    input  logic             amount_valid,
    input  logic             exit,
    input  logic             home,
    output logic [BAL_W-1:0] balance_out,
    output logic [3:0]       state_out,
    output logic             txn_ok,
    output logic             txn_err,
    output logic             card_eject,
    output logic             card_locked,
    output logic [3:0]       tries_left
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        LANG     = 4'd1,
        PIN      = 4'd2,
        MENU     = 4'd3,
        WDRAW    = 4'd4,
        DEPOSIT  = 4'd5,
        SHOW_BAL = 4'd6,
        CHPIN    = 4'd7,
        EJECT    = 4'd8,
        LOCKED   = 4'd15
    } state_t;

    localparam int               TIMER_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       TRIES_INIT = 4'(MAX_TRIES);
    localparam logic [BAL_W-1:0] BAL_INIT   = BAL_W'(INIT_BALANCE);

    state_t             state, state_n;
    logic [PIN_W-1:0]   pin_q, pin_n;
    logic [BAL_W-1:0]   bal_n;
    logic [3:0]         tries_n;
    logic [TIMER_W-1:0] timer, timer_n;
    logic               ok_n, err_n;

    logic               active, active_n, strobe, timeout, in_txn;
    logic [BAL_W-1:0]   amt_ext;
    logic [BAL_W:0]     dep_sum;

    assign state_out = state;

    // State register and all registered outputs. Reset discards any
    // transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            balance_out <= BAL_INIT;
            pin_q       <= DEFAULT_PIN;
            tries_left  <= TRIES_INIT;
            timer       <= '0;
            txn_ok      <= 1'b0;
            txn_err     <= 1'b0;
            card_eject  <= 1'b0;
            card_locked <= 1'b0;
        end else begin
            state       <= state_n;
            balance_out <= bal_n;
            pin_q       <= pin_n;
            tries_left  <= tries_n;
            timer       <= timer_n;
            txn_ok      <= ok_n;
            txn_err     <= err_n;
            card_eject  <= (state_n == EJECT);
            card_locked <= (state_n == LOCKED);
        end
    end

    // Next-state and datapath. Inside a session the order is: exit,
    // inactivity timeout, home, then the strobe owned by the current state.
    always_comb begin
        state_n  = state;
        bal_n    = balance_out;
        pin_n    = pin_q;
        tries_n  = tries_left;
        ok_n     = 1'b0;
        err_n    = 1'b0;

        active   = (state >= LANG) && (state <= CHPIN);
        in_txn   = (state >= WDRAW) && (state <= CHPIN);
        strobe   = lang_sel | pin_valid | op_valid | amount_valid | home;
        timeout  = (timer == TIMER_LAST);
        amt_ext  = BAL_W'(amount);
        // One extra bit keeps the deposit carry so overflow can be detected.
        dep_sum  = {1'b0, balance_out} + {1'b0, amt_ext};

        case (state)
            IDLE: begin
                if (card_in) state_n = LANG;
            end
            EJECT: begin
                state_n = IDLE;
                tries_n = TRIES_INIT;
            end
            LOCKED: begin
                state_n = LOCKED;
            end
            LANG, PIN, MENU, WDRAW, DEPOSIT, SHOW_BAL, CHPIN: begin
                if (exit || timeout) begin
                    state_n = EJECT;
                end else if (home && in_txn) begin
                    state_n = MENU;
                end else begin
                    case (state)
                        LANG: if (lang_sel) state_n = PIN;
                        PIN: begin
                            if (pin_valid) begin
                                if (pin_in == pin_q) begin
                                    state_n = MENU;
                                    tries_n = TRIES_INIT;
                                end else if (tries_left <= 4'd1) begin
                                    state_n = LOCKED;
                                    tries_n = 4'd0;
                                end else begin
                                    tries_n = tries_left - 4'd1;
                                end
                            end
                        end
                        MENU: begin
                            if (op_valid) begin
                                case (op)
                                    2'b00: begin
                                        state_n = SHOW_BAL;
                                        ok_n    = 1'b1;
                                    end
                                    2'b01:   state_n = WDRAW;
                                    2'b10:   state_n = DEPOSIT;
                                    default: state_n = CHPIN;
                                endcase
                            end
                        end
                        WDRAW: begin
                            if (amount_valid) begin
                                state_n = MENU;
                                if (amt_ext <= balance_out) begin
                                    bal_n = balance_out - amt_ext;
                                    ok_n  = 1'b1;
                                end else begin
                                    err_n = 1'b1;
                                end
                            end
                        end
                        DEPOSIT: begin
                            if (amount_valid) begin
                                state_n = MENU;
                                if (dep_sum[BAL_W]) begin
                                    err_n = 1'b1;
                                end else begin
                                    bal_n = dep_sum[BAL_W-1:0];
                                    ok_n  = 1'b1;
                                end
                            end
                        end
                        CHPIN: begin
                            if (amount_valid) begin
                                state_n = MENU;
                                pin_n   = PIN_W'(amount);
                                ok_n    = 1'b1;
                            end
                        end
                        default: state_n = state;
                    endcase
                end
            end
            default: state_n = IDLE;
        endcase

        // The idle timer only runs while a session stays open with no strobe.
        active_n = (state_n >= LANG) && (state_n <= CHPIN);
        if (active && active_n && !strobe)
            timer_n = timer + TIMER_W'(1);
        else
            timer_n = '0;
    end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl
// Directed bench for atm_session_ctrl with TIMEOUT_CYCLES = 8. A behavioural
// model of the session rules runs next to the DUT and is compared on every
// cycle. Hand-computed literal expectations at key points pin both the DUT
// and the model.
module tb_atm_session_ctrl;

    localparam int TO       = 8;
    localparam int MAXT     = 3;
    localparam int INIT_BAL = 30;
    localparam int BAL_MAX  = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       card_in = 1'b0;
    logic       lang_sel = 1'b0;
    logic [3:0] pin_in = 4'h0;
    logic       pin_valid = 1'b0;
    logic [1:0] op = 2'b00;
    logic       op_valid = 1'b0;
    logic [5:0] amount = 6'd0;
    logic       amount_valid = 1'b0;
    logic       exit = 1'b0;
    logic       home = 1'b0;
    logic [7:0] balance_out;
    logic [3:0] state_out;
    logic       txn_ok, txn_err, card_eject, card_locked;
    logic [3:0] tries_left;

    int checks = 0;
    int errors = 0;

    // Model of the session, kept as plain integers.
    int mState, mBal, mPin, mTries, mTimer;
    int mOk, mErr, mEject, mLocked;

    atm_session_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .card_in(card_in), .lang_sel(lang_sel),
        .pin_in(pin_in), .pin_valid(pin_valid), .op(op), .op_valid(op_valid),
        .amount(amount), .amount_valid(amount_valid), .exit(exit), .home(home),
        .balance_out(balance_out), .state_out(state_out), .txn_ok(txn_ok),
        .txn_err(txn_err), .card_eject(card_eject), .card_locked(card_locked),
        .tries_left(tries_left)
    );

    always #5 clk = ~clk;

    task automatic checkField(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit isSession(input int s);
        return (s >= 1) && (s <= 7);
    endfunction

    // Advance the model by one clock using the inputs the DUT sees.
    task automatic modelStep();
        int  nxt;
        bit  anyStrobe;
        if (rst) begin
            mState = 0; mBal = INIT_BAL; mPin = 15; mTries = MAXT; mTimer = 0;
            mOk = 0; mErr = 0; mEject = 0; mLocked = 0;
            return;
        end
        mOk = 0;
        mErr = 0;
        nxt = mState;
        anyStrobe = lang_sel || pin_valid || op_valid || amount_valid || home;
        if (mState == 0) begin
            if (card_in) nxt = 1;
        end else if (mState == 8) begin
            nxt = 0;
            mTries = MAXT;
        end else if (mState == 15) begin
            nxt = 15;
        end else if (exit || mTimer == TO - 1) begin
            nxt = 8;
        end else if (home && mState >= 4) begin
            nxt = 3;
        end else if (mState == 1) begin
            if (lang_sel) nxt = 2;
        end else if (mState == 2) begin
            if (pin_valid) begin
                if (int'(pin_in) == mPin) begin
                    nxt = 3;
                    mTries = MAXT;
                end else begin
                    mTries = mTries - 1;
                    if (mTries == 0) nxt = 15;
                end
            end
        end else if (mState == 3) begin
            if (op_valid) begin
                nxt = 6 - int'(op) + ((op == 2'b00) ? 0 : ((op == 2'b11) ? 4 : 0)) - ((op == 2'b01) ? 1 : 0) - ((op == 2'b10) ? 1 : 0);
                nxt = (op == 2'b00) ? 6 : (op == 2'b01) ? 4 : (op == 2'b10) ? 5 : 7;
                if (op == 2'b00) mOk = 1;
            end
        end else if (amount_valid) begin
            nxt = 3;
            if (mState == 4) begin
                if (int'(amount) <= mBal) begin mBal = mBal - int'(amount); mOk = 1; end
                else mErr = 1;
            end else if (mState == 5) begin
                if (mBal + int'(amount) > BAL_MAX) mErr = 1;
                else begin mBal = mBal + int'(amount); mOk = 1; end
            end else if (mState == 7) begin
                mPin = int'(amount) % 16;
                mOk = 1;
            end else begin
                nxt = mState;
            end
        end
        if (isSession(mState) && isSession(nxt) && !anyStrobe) mTimer = mTimer + 1;
        else mTimer = 0;
        mEject  = (nxt == 8) ? 1 : 0;
        mLocked = (nxt == 15) ? 1 : 0;
        mState  = nxt;
    endtask

    task automatic checkOutput();
        checkField("state_out", state_out, mState);
        checkField("balance_out", balance_out, mBal);
        checkField("tries_left", tries_left, mTries);
        checkField("txn_ok", txn_ok, mOk);
        checkField("txn_err", txn_err, mErr);
        checkField("card_eject", card_eject, mEject);
        checkField("card_locked", card_locked, mLocked);
    endtask

    // Compare process: step the model on each rising edge, then check the
    // registered outputs just after they settle.
    always @(posedge clk) begin
        modelStep();
        #1;
        checkOutput();
    end

    // Hold one stimulus for a single cycle (from negedge to negedge), then
    // drop every strobe. "idle" just waits the given number of cycles.
    task automatic applyStimulus(input string kind, input int value);
        if (kind == "idle") begin
            repeat (value) @(negedge clk);
            return;
        end
        case (kind)
            "rst":     rst = 1'b1;
            "card":    card_in = 1'b1;
            "lang":    lang_sel = 1'b1;
            "pin":     begin pin_in = 4'(value); pin_valid = 1'b1; end
            "op":      begin op = 2'(value); op_valid = 1'b1; end
            "amt":     begin amount = 6'(value); amount_valid = 1'b1; end
            "home":    home = 1'b1;
            "exit":    exit = 1'b1;
            "exitamt": begin exit = 1'b1; amount = 6'(value); amount_valid = 1'b1; end
            "rstamt":  begin rst = 1'b1; amount = 6'(value); amount_valid = 1'b1; end
            default:   $display("[TB] unknown stimulus %s", kind);
        endcase
        @(negedge clk);
        rst = 1'b0; card_in = 1'b0; lang_sel = 1'b0; pin_valid = 1'b0;
        op_valid = 1'b0; amount_valid = 1'b0; exit = 1'b0; home = 1'b0;
    endtask

    task automatic login(input int p);
        applyStimulus("card", 0);
        applyStimulus("lang", 0);
        applyStimulus("pin", p);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkField("lit_reset_state", state_out, 0);
        checkField("lit_reset_bal", balance_out, 30);
        checkField("lit_reset_tries", tries_left, 3);
        checkField("lit_reset_locked", card_locked, 0);

        $display("[TB] login and underflow");
        applyStimulus("card", 0);
        checkField("lit_lang", state_out, 1);
        applyStimulus("lang", 0);
        checkField("lit_pin", state_out, 2);
        applyStimulus("pin", 15);
        checkField("lit_menu", state_out, 3);
        applyStimulus("op", 1);
        checkField("lit_wdraw", state_out, 4);
        applyStimulus("amt", 31);
        checkField("lit_under_err", txn_err, 1);
        checkField("lit_under_bal", balance_out, 30);

        $display("[TB] happy path withdraw");
        applyStimulus("op", 1);
        applyStimulus("amt", 10);
        checkField("lit_wd_bal", balance_out, 20);
        checkField("lit_wd_ok", txn_ok, 1);
        checkField("lit_wd_state", state_out, 3);
        checkField("lit_model_bal20", mBal, 20);

        $display("[TB] deposits and overflow");
        applyStimulus("op", 2); applyStimulus("amt", 63);
        applyStimulus("op", 2); applyStimulus("amt", 63);
        applyStimulus("op", 2); applyStimulus("amt", 63);
        applyStimulus("op", 2); applyStimulus("amt", 41);
        checkField("lit_dep_250", balance_out, 250);
        applyStimulus("op", 2); applyStimulus("amt", 10);
        checkField("lit_over_err", txn_err, 1);
        checkField("lit_over_bal", balance_out, 250);
        checkField("lit_model_bal250", mBal, 250);
        applyStimulus("op", 2); applyStimulus("amt", 5);
        checkField("lit_dep_255", balance_out, 255);
        checkField("lit_dep_255_ok", txn_ok, 1);
        applyStimulus("op", 1); applyStimulus("amt", 0);
        checkField("lit_wd0_ok", txn_ok, 1);
        checkField("lit_wd0_bal", balance_out, 255);
        applyStimulus("op", 1); applyStimulus("amt", 63);
        checkField("lit_wd63_bal", balance_out, 192);

        $display("[TB] show balance and home");
        applyStimulus("op", 0);
        checkField("lit_show_state", state_out, 6);
        checkField("lit_show_ok", txn_ok, 1);
        applyStimulus("home", 0);
        checkField("lit_home_menu", state_out, 3);
        applyStimulus("op", 1);
        applyStimulus("home", 0);
        checkField("lit_home_wd", state_out, 3);
        checkField("lit_home_wd_bal", balance_out, 192);

        $display("[TB] PIN change and exit");
        applyStimulus("op", 3);
        applyStimulus("amt", 5);
        checkField("lit_chpin_ok", txn_ok, 1);
        applyStimulus("exit", 0);
        checkField("lit_exit_eject", card_eject, 1);
        checkField("lit_exit_state", state_out, 8);
        applyStimulus("idle", 1);
        checkField("lit_eject_done", card_eject, 0);
        checkField("lit_idle_after", state_out, 0);
        login(15);
        checkField("lit_oldpin_state", state_out, 2);
        checkField("lit_oldpin_tries", tries_left, 2);
        applyStimulus("pin", 5);
        checkField("lit_newpin_menu", state_out, 3);
        checkField("lit_newpin_tries", tries_left, 3);

        $display("[TB] inactivity timeout");
        applyStimulus("idle", TO - 1);
        checkField("lit_to_still_menu", state_out, 3);
        applyStimulus("idle", 1);
        checkField("lit_to_eject", card_eject, 1);
        applyStimulus("idle", 1);
        checkField("lit_to_idle", state_out, 0);
        checkField("lit_to_eject_low", card_eject, 0);

        $display("[TB] exit with amount strobe");
        login(5);
        applyStimulus("op", 1);
        applyStimulus("exitamt", 10);
        checkField("lit_exitamt_state", state_out, 8);
        checkField("lit_exitamt_bal", balance_out, 192);
        checkField("lit_exitamt_ok", txn_ok, 0);
        applyStimulus("idle", 1);

        $display("[TB] reset during withdraw");
        login(5);
        applyStimulus("op", 1);
        applyStimulus("rstamt", 10);
        checkField("lit_rst_state", state_out, 0);
        checkField("lit_rst_bal", balance_out, 30);
        checkField("lit_rst_ok", txn_ok, 0);

        $display("[TB] lockout");
        login(3);
        checkField("lit_lock_t2", tries_left, 2);
        applyStimulus("pin", 3);
        checkField("lit_lock_t1", tries_left, 1);
        applyStimulus("pin", 3);
        checkField("lit_lock_t0", tries_left, 0);
        checkField("lit_lock_state", state_out, 15);
        checkField("lit_lock_level", card_locked, 1);
        applyStimulus("card", 0);
        applyStimulus("lang", 0);
        applyStimulus("pin", 15);
        applyStimulus("exit", 0);
        applyStimulus("idle", 3);
        checkField("lit_lock_hold", state_out, 15);
        checkField("lit_lock_hold_lvl", card_locked, 1);
        applyStimulus("rst", 0);
        checkField("lit_unlock_state", state_out, 0);
        checkField("lit_unlock_lvl", card_locked, 0);
        checkField("lit_unlock_tries", tries_left, 3);

        applyStimulus("idle", 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
